// File: rtl/fsk_dem_win.sv
// ---------------------------------------------------------------------------
// fsk_dem_win -- windowed FSK bit slicer
//
// Counts transitions of sig_rf over back-to-back windows of WIN_LEN enabled
// sysclk cycles. At the end of each window it decides the bit: many edges = 1,
// few edges = 0. It also raises a one-cycle valid strobe, reports the edge
// count, flags carrier loss and counts decided symbols.
//
// Optional feature macro: FSK_DEM_HYST_EN
//   defined     : the decision threshold depends on the previous decided bit
//                 (THRESH-HYST when the previous bit was 1,
//                 THRESH+HYST when it was 0).
//   not defined : the bit is 1 when edge count >= THRESH.
//
// Ports
//   sysclk      in   1      system clock, rising edge
//   reset       in   1      asynchronous active-low reset
//   sig_enable  in   1      1 = demodulate; 0 = abort the current window and idle
//   sig_rf      in   1      hard-limited FSK input, synchronous to sysclk
//   sig_reb     out  1      decided bit of the last completed window
//   reb_valid   out  1      one-cycle strobe: sig_reb/judge_Ts were just updated
//   judge_Ts    out  CNT_W  edge count of the last completed window
//   carrier_ok  out  1      0 when the last window had < CARRIER_MIN edges
//   sym_cnt     out  SYM_W  windows decided since reset, wraps
// ---------------------------------------------------------------------------
module fsk_dem_win #(
  parameter int WIN_LEN     = 16,
  parameter int THRESH      = 6,
  parameter int CARRIER_MIN = 2,
  parameter int HYST        = 1,
  parameter int SYM_W       = 16,
  localparam int CNT_W      = $clog2(WIN_LEN + 1)
) (
  input  logic             sysclk,
  input  logic             reset,
  input  logic             sig_enable,
  input  logic             sig_rf,
  output logic             sig_reb,
  output logic             reb_valid,
  output logic [CNT_W-1:0] judge_Ts,
  output logic             carrier_ok,
  output logic [SYM_W-1:0] sym_cnt
);

  localparam int WIN_W = $clog2(WIN_LEN);
  localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(WIN_LEN - 1);

  // Refuse configurations where the window is too short or the hysteresis
  // margin would push the lower threshold to zero or below.
  if (WIN_LEN < 4 || HYST >= THRESH) begin : g_param_check
    $error("fsk_dem_win: need WIN_LEN >= 4 and HYST < THRESH");
  end

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    COUNT = 1'b1
  } state_t;

  state_t             state;
  state_t             state_nxt;
  logic               sig_temp;
  logic [WIN_W-1:0]   win_cnt;
  logic [WIN_W-1:0]   win_nxt;
  logic [CNT_W-1:0]   edge_acc;
  logic [CNT_W-1:0]   acc_nxt;
  logic [CNT_W-1:0]   total;
  logic               rf_edge;
  logic               last_win;

  // Bit decision for a completed window; prev is the previously decided bit.
  function automatic logic decide(input logic [CNT_W-1:0] cnt, input logic prev);
    logic res;
`ifdef FSK_DEM_HYST_EN
    if (prev) begin
      res = (int'(cnt) >= (THRESH - HYST));
    end else begin
      res = (int'(cnt) >= (THRESH + HYST));
    end
`else
    res = (int'(cnt) >= THRESH);
    if (prev) begin
      res = res;
    end else begin
      res = res;
    end
`endif
    return res;
  endfunction

  // An edge is any difference between this cycle's sample and the last one.
  assign rf_edge = sig_rf ^ sig_temp;

  // Previous-sample register: tracks sig_rf every cycle, enabled or not, so
  // the first cycle of a window sees a valid reference.
  always_ff @(posedge sysclk or negedge reset) begin
    if (!reset) begin
      sig_temp <= 1'b0;
    end else begin
      sig_temp <= sig_rf;
    end
  end

  // FSM state register.
  always_ff @(posedge sysclk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state and window datapath. win_cnt is always 0 in IDLE, so the
  // first enabled cycle is handled exactly like any window cycle 0.
  always_comb begin
    state_nxt = state;
    win_nxt   = win_cnt;
    acc_nxt   = edge_acc;
    last_win  = 1'b0;
    total     = edge_acc + CNT_W'(rf_edge);

    case (state)
      IDLE: begin
        if (sig_enable) begin
          state_nxt = COUNT;
        end else begin
          state_nxt = IDLE;
        end
      end
      COUNT: begin
        if (sig_enable) begin
          state_nxt = COUNT;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase

    if (sig_enable) begin
      if (win_cnt == WIN_LAST) begin
        win_nxt  = '0;
        acc_nxt  = '0;
        last_win = 1'b1;
      end else begin
        win_nxt  = win_cnt + WIN_W'(1);
        acc_nxt  = total;
      end
    end else begin
      // Dropping enable discards the partial window.
      win_nxt = '0;
      acc_nxt = '0;
    end
  end

  // Window counters.
  always_ff @(posedge sysclk or negedge reset) begin
    if (!reset) begin
      win_cnt  <= '0;
      edge_acc <= '0;
    end else begin
      win_cnt  <= win_nxt;
      edge_acc <= acc_nxt;
    end
  end

  // Result registers: updated only on the last window cycle, held otherwise.
  always_ff @(posedge sysclk or negedge reset) begin
    if (!reset) begin
      sig_reb    <= 1'b0;
      reb_valid  <= 1'b0;
      judge_Ts   <= '0;
      carrier_ok <= 1'b0;
      sym_cnt    <= '0;
    end else begin
      reb_valid <= last_win;
      if (last_win) begin
        judge_Ts   <= total;
        sig_reb    <= decide(total, sig_reb);
        carrier_ok <= (int'(total) >= CARRIER_MIN);
        sym_cnt    <= sym_cnt + SYM_W'(1);
      end else begin
        judge_Ts   <= judge_Ts;
        sig_reb    <= sig_reb;
        carrier_ok <= carrier_ok;
        sym_cnt    <= sym_cnt;
      end
    end
  end

endmodule

// File: tb/tb_fsk_dem_win.sv
// ---------------------------------------------------------------------------
// tb_fsk_dem_win -- directed, table-driven bench for fsk_dem_win (default
// parameters). A second instance with SYM_W=2 shares the stimulus so that
// symbol-counter wrap can be checked. Inputs are driven and outputs sampled
// on the falling edge. Bit i of each 16-bit pattern is sig_rf in window
// cycle i; sig_rf is 0 immediately before every table window.
// ---------------------------------------------------------------------------
module tb_fsk_dem_win;

  logic        sysclk = 1'b0;
  logic        reset;
  logic        sig_enable;
  logic        sig_rf;
  logic        sig_reb,  sig_reb2;
  logic        reb_valid, reb_valid2;
  logic [4:0]  judge_Ts, judge_Ts2;
  logic        carrier_ok, carrier_ok2;
  logic [15:0] sym_cnt;
  logic [1:0]  sym_cnt2;

  int vec_cnt  = 0;
  int fail_cnt = 0;

  // model of held outputs
  int exp_sym  = 0;
  int last_j   = 0;
  int last_reb = 0;
  int last_car = 0;

  always #5 sysclk = ~sysclk;

  fsk_dem_win dut (
    .sysclk(sysclk), .reset(reset), .sig_enable(sig_enable), .sig_rf(sig_rf),
    .sig_reb(sig_reb), .reb_valid(reb_valid), .judge_Ts(judge_Ts),
    .carrier_ok(carrier_ok), .sym_cnt(sym_cnt)
  );

  fsk_dem_win #(.SYM_W(2)) dut2 (
    .sysclk(sysclk), .reset(reset), .sig_enable(sig_enable), .sig_rf(sig_rf),
    .sig_reb(sig_reb2), .reb_valid(reb_valid2), .judge_Ts(judge_Ts2),
    .carrier_ok(carrier_ok2), .sym_cnt(sym_cnt2)
  );

  typedef struct {
    string       name;
    logic [15:0] pat;
    int          exp_j;
    int          exp_reb;
    int          exp_car;
  } vec_t;

  vec_t tbl [8];

  task automatic chk(input string name, input int act, input int exp);
    vec_cnt++;
    if (act != exp) begin
      fail_cnt++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_held(input string tag);
    chk({tag, " judge_Ts"},   int'(judge_Ts),   last_j);
    chk({tag, " sig_reb"},    int'(sig_reb),    last_reb);
    chk({tag, " carrier_ok"}, int'(carrier_ok), last_car);
    chk({tag, " sym_cnt"},    int'(sym_cnt),    exp_sym % 65536);
    chk({tag, " sym_cnt2"},   int'(sym_cnt2),   exp_sym % 4);
  endtask

  // Drive n enabled cycles of pat (from bit 0), expecting no strobe.
  task automatic partial(input string tag, input logic [15:0] pat, input int n);
    logic [15:0] p;
    p = pat;
    for (int i = 0; i < n; i++) begin
      sig_enable = 1'b1;
      sig_rf     = p[i];
      @(negedge sysclk);
      chk({tag, " no strobe"}, int'(reb_valid), 0);
    end
  endtask

  // Full window: 15 strobe-free cycles, then strobe with results.
  task automatic window(input string tag, input logic [15:0] pat,
                        input int ej, input int er, input int ec);
    logic [15:0] p;
    p = pat;
    partial(tag, p, 15);
    sig_enable = 1'b1;
    sig_rf     = p[15];
    @(negedge sysclk);
    exp_sym++;
    last_j = ej; last_reb = er; last_car = ec;
    chk({tag, " reb_valid"},  int'(reb_valid),  1);
    chk({tag, " reb_valid2"}, int'(reb_valid2), 1);
    chk_held(tag);
  endtask

  task automatic idle(input string tag, input int n);
    for (int i = 0; i < n; i++) begin
      sig_enable = 1'b0;
      sig_rf     = 1'b0;
      @(negedge sysclk);
      chk({tag, " idle no strobe"}, int'(reb_valid), 0);
    end
  endtask

  initial begin
    tbl[0] = '{"tog2",   16'h3333,  8, 1, 1};
    tbl[1] = '{"tog4",   16'h0F0F,  4, 0, 1};
    tbl[2] = '{"const",  16'h0000,  0, 0, 0};
    tbl[3] = '{"six",    16'h0333,  6, 1, 1};
    tbl[4] = '{"five",   16'hFF33,  5, 0, 1};
    tbl[5] = '{"one",    16'hFFFF,  1, 0, 0};
    tbl[6] = '{"two",    16'h00FF,  2, 0, 1};
    tbl[7] = '{"tog1",   16'h5555, 16, 1, 1};

    reset = 1'b0; sig_enable = 1'b0; sig_rf = 1'b0;
    @(negedge sysclk);
    @(negedge sysclk);
    chk("rst reb_valid", int'(reb_valid), 0);
    chk_held("rst");
    reset = 1'b1;
    idle("post-rst", 2);

    // Four back-to-back windows, enable held 64 cycles.
    for (int w = 0; w < 4; w++) window("b2b", 16'h3333, 8, 1, 1);
    idle("b2b end", 2);
    chk("b2b sym_cnt=4", int'(sym_cnt), 4);
    chk("b2b sym_cnt2 wrap", int'(sym_cnt2), 0);

    // Table of single windows.
    for (int v = 0; v < 8; v++) begin
      window(tbl[v].name, tbl[v].pat, tbl[v].exp_j, tbl[v].exp_reb, tbl[v].exp_car);
      idle(tbl[v].name, 2);
    end

    // Abort at window cycle 9, re-enable 5 cycles later.
    window("pre-abort", 16'h3333, 8, 1, 1);
    idle("pre-abort", 1);
    partial("abort", 16'h5555, 9);
    idle("abort", 5);
    chk_held("abort hold");
    window("after abort", 16'h0F0F, 4, 0, 1);
    idle("after abort", 1);

    // Enable dropped on the last window cycle: no decision.
    partial("last drop", 16'h5555, 15);
    idle("last drop", 3);
    chk_held("last drop hold");

    // Reset at window cycle 7.
    partial("rst mid", 16'h5555, 7);
    #1 reset = 1'b0;
    #1;
    exp_sym = 0; last_j = 0; last_reb = 0; last_car = 0;
    chk("async rst reb_valid", int'(reb_valid), 0);
    chk_held("async rst");
    @(negedge sysclk);
    reset = 1'b1;
    idle("post rst2", 2);
    window("first after rst", 16'h3333, 8, 1, 1);
    chk("sym_cnt=1 after rst", int'(sym_cnt), 1);
    idle("end", 1);

    // Wrap of the 2-bit counter: strobes 2..5 give 2,3,0,1.
    for (int w = 0; w < 4; w++) window("wrap", 16'h0F0F, 4, 0, 1);
    chk("wrap sym_cnt2 after 5", int'(sym_cnt2), 1);
    idle("wrap end", 1);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, fail_cnt);
    $finish;
  end

endmodule
